mini_src_control_unit: RTL and testbench
========================================

Name: mini_src_control_unit

Overview:
- Hardwired Moore control unit that sequences the Mini SRC bus datapath.
- Drives the datapath's register-in/out strobes, memory Read/Write, IncPC, CONin and ALU operation select, one control step per clock.
- Runs fetch (T0-T2), then an opcode-specific execute sequence, then returns to T0.
- Replaces the hand-written state sequencing currently done in benches.

Parameters:
OPW, 5, opcode width; opcode field is IR[31:27].
ALUW, 4, width of ALUop select.

Ports:
Clock  input  1  system clock, rising edge.
Reset_n  input  1  asynchronous active-low reset.
IR  input  32  instruction register contents from datapath.
CON  input  1  CON_FF output (branch condition true).
Stop  input  1  halt request, sampled at the fetch boundary.
Run  output  1  1 while executing, 0 in reset/halt.
PCout, MDRout, ZLOout, ZHIout, HIout, LOout, INPORTout, Cout  output  1 each  bus-out strobes.
PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, OUTPORTin, CONin  output  1 each  register-load strobes.
Gra, Grb, Grc, Rin, Rout, BAout  output  1 each  register-file select/control.
Read, Write, IncPC  output  1 each  memory read, memory write, PC increment via ALU.
ALUop  output  ALUW  0 ADD, 1 SUB, 2 AND, 3 OR; 0 when unused.

Behaviour:
- Reset: Reset_n low forces state RESET asynchronously. In RESET, every strobe and ALUop is 0 and Run is 0. The first rising edge after release enters T0 with Run=1.
- Outputs are purely decoded from the current state (Moore). All strobes not listed for a state are 0.
- Every state lasts exactly one clock.
- Fetch:
  - T0: PCout MARin IncPC Zin.
  - T1: ZLOout PCin Read MDRin.
  - T2: MDRout IRin.
- At the T2 exit, IR[31:27] selects the execute path:
  - add 00011, sub 00100, and 00101, or 00110:
    - T3 Grb Rout Yin.
    - T4 Grc Rout Zin, ALUop per opcode.
    - T5 ZLOout Gra Rin.
  - addi 01100:
    - T3 Grb Rout Yin.
    - T4 Cout Zin, ALUop=ADD.
    - T5 ZLOout Gra Rin.
  - ldi 00001:
    - T3 Grb BAout Yin.
    - T4 Cout Zin, ALUop=ADD.
    - T5 ZLOout Gra Rin.
  - ld 00000:
    - T3-T4 as ldi.
    - T5 ZLOout MARin.
    - T6 Read MDRin.
    - T7 MDRout Gra Rin.
  - st 00010:
    - T3-T5 as ld.
    - T6 Gra Rout MDRin (Read=0).
    - T7 Write.
  - br 10010:
    - T3 Gra Rout CONin.
    - T4 PCout Yin.
    - T5 Cout Zin, ALUop=ADD.
    - T6 ZLOout, with PCin=CON (CON read in T6, after the T3 load).
  - jr 10011: T3 Gra Rout PCin.
  - in 10101: T3 INPORTout Gra Rin.
  - out 10110: T3 Gra Rout OUTPORTin.
  - mfhi 10111: T3 HIout Gra Rin.
  - mflo 11000: T3 LOout Gra Rin.
  - nop 11001, and any undefined opcode: go straight from T2 to T0 with no execute step.
  - halt 11010: enter HALT.
- The final execute state of every path goes to T0.
- Stop: sampled on the edge that would enter T0. If Stop=1, go to HALT instead; the current instruction always completes.
- HALT: all strobes 0, Run=0. HALT is held until Reset_n is asserted; Stop deasserting does not leave HALT.
- Reset asserted mid-instruction aborts immediately: strobes drop to 0 without waiting for a clock edge, and no partial Write is issued after the reset edge.
- Gra/Grb/Grc are never asserted together in one state. At most one bus-out strobe is asserted per state.

Test Plan:
- Reset_n low, then release; IR=0xC8000000 (nop) → T0 asserts PCout, MARin, IncPC, Zin; T1 ZLOout, PCin, Read, MDRin; T2 MDRout, IRin; fourth cycle back in T0; Run=1.
- IR=0x18918000 (add R1,R2,R3) → T4 has Grc, Rout, Zin with ALUop=0; T5 has ZLOout, Gra, Rin; total 6 cycles.
- IR opcode 10010 (br) with CON=1 → T6 has ZLOout=1, PCin=1. Repeat with CON=0 → T6 has ZLOout=1, PCin=0. Both return to T0 next cycle.
- IR opcode 00010 (st) → Write=1 only in T7; Read=0 in T6; instruction takes 8 cycles.
- Stop=1 during T4 of an addi → T5 completes with Rin=1, then HALT with Run=0 and all strobes 0. HALT persists after Stop=0 until Reset_n pulses.
- Reset_n pulled low mid-T6 of ld → all outputs 0 within the same cycle. After release, execution restarts at T0.

Source files
------------

// File: rtl/mini_src_control_unit.sv
// Hardwired Moore control unit for the Mini SRC bus datapath.
// Each state lasts one clock. The fetch (T0-T2) is followed by an opcode-specific execute path.
//
// state   | meaning
// --------+------------------------------------------------------------
// RESET   | held while Reset_n is low; all strobes off, Run=0
// T0..T2  | instruction fetch
// T3..T7  | execute steps; the path is chosen by the opcode latched at T2 exit
// HALT    | stopped; only a Reset_n pulse leaves this state
module mini_src_control_unit #(
    parameter int OPW  = 5,
    parameter int ALUW = 4
) (
    input  logic            Clock,
    input  logic            Reset_n,
    input  logic [31:0]     IR,
    input  logic            CON,
    input  logic            Stop,
    output logic            Run,
    output logic            PCout,
    output logic            MDRout,
    output logic            ZLOout,
    output logic            ZHIout,
    output logic            HIout,
    output logic            LOout,
    output logic            INPORTout,
    output logic            Cout,
    output logic            PCin,
    output logic            MARin,
    output logic            MDRin,
    output logic            IRin,
    output logic            Yin,
    output logic            Zin,
    output logic            HIin,
    output logic            LOin,
    output logic            OUTPORTin,
    output logic            CONin,
    output logic            Gra,
    output logic            Grb,
    output logic            Grc,
    output logic            Rin,
    output logic            Rout,
    output logic            BAout,
    output logic            Read,
    output logic            Write,
    output logic            IncPC,
    output logic [ALUW-1:0] ALUop
);

    typedef enum logic [3:0] {
        S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    localparam logic [OPW-1:0] OP_LD   = OPW'(0);
    localparam logic [OPW-1:0] OP_LDI  = OPW'(1);
    localparam logic [OPW-1:0] OP_ST   = OPW'(2);
    localparam logic [OPW-1:0] OP_ADD  = OPW'(3);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(4);
    localparam logic [OPW-1:0] OP_AND  = OPW'(5);
    localparam logic [OPW-1:0] OP_OR   = OPW'(6);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(12);
    localparam logic [OPW-1:0] OP_BR   = OPW'(18);
    localparam logic [OPW-1:0] OP_JR   = OPW'(19);
    localparam logic [OPW-1:0] OP_IN   = OPW'(21);
    localparam logic [OPW-1:0] OP_OUT  = OPW'(22);
    localparam logic [OPW-1:0] OP_MFHI = OPW'(23);
    localparam logic [OPW-1:0] OP_MFLO = OPW'(24);
    localparam logic [OPW-1:0] OP_HALT = OPW'(26);

    typedef struct packed {
        logic            run;
        logic            pc_out;
        logic            mdr_out;
        logic            zlo_out;
        logic            zhi_out;
        logic            hi_out;
        logic            lo_out;
        logic            inport_out;
        logic            c_out;
        logic            pc_in;
        logic            mar_in;
        logic            mdr_in;
        logic            ir_in;
        logic            y_in;
        logic            z_in;
        logic            hi_in;
        logic            lo_in;
        logic            outport_in;
        logic            con_in;
        logic            gra;
        logic            grb;
        logic            grc;
        logic            r_in;
        logic            r_out;
        logic            ba_out;
        logic            read;
        logic            write;
        logic            inc_pc;
        logic            pc_in_con;
        logic [ALUW-1:0] alu_op;
    } ctrl_t;

    state_t         state_q, state_d;
    logic [OPW-1:0] op_q, op_d;
    ctrl_t          ctrl_q;
    logic           fin;
    logic           unused_ir_bits;

    assign unused_ir_bits = ^IR[31-OPW:0];

    function automatic logic is_alu(input logic [OPW-1:0] op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR};
    endfunction

    function automatic logic is_mem(input logic [OPW-1:0] op);
        return op inside {OP_LD, OP_ST};
    endfunction

    function automatic logic is_short(input logic [OPW-1:0] op);
        return op inside {OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO};
    endfunction

    function automatic logic has_exec(input logic [OPW-1:0] op);
        return is_alu(op) || is_mem(op) || is_short(op) ||
               (op inside {OP_ADDI, OP_LDI, OP_BR});
    endfunction

    function automatic logic [ALUW-1:0] alu_sel(input logic [OPW-1:0] op);
        logic [ALUW-1:0] a;
        a = '0;
        if (op == OP_SUB) a = ALUW'(1);
        if (op == OP_AND) a = ALUW'(2);
        if (op == OP_OR)  a = ALUW'(3);
        return a;
    endfunction

    function automatic ctrl_t decode(input state_t s, input logic [OPW-1:0] op);
        ctrl_t c;
        c = '0;
        c.run = (s != S_RESET) && (s != S_HALT);
        case (s)
            S_T0: begin
                c.pc_out = 1'b1; c.mar_in = 1'b1; c.inc_pc = 1'b1; c.z_in = 1'b1;
            end
            S_T1: begin
                c.zlo_out = 1'b1; c.pc_in = 1'b1; c.read = 1'b1; c.mdr_in = 1'b1;
            end
            S_T2: begin
                c.mdr_out = 1'b1; c.ir_in = 1'b1;
            end
            S_T3: begin
                if (is_alu(op) || op == OP_ADDI) begin
                    c.grb = 1'b1; c.r_out = 1'b1; c.y_in = 1'b1;
                end else if (is_mem(op) || op == OP_LDI) begin
                    c.grb = 1'b1; c.ba_out = 1'b1; c.y_in = 1'b1;
                end else begin
                    case (op)
                        OP_BR:   begin c.gra = 1'b1; c.r_out = 1'b1; c.con_in = 1'b1; end
                        OP_JR:   begin c.gra = 1'b1; c.r_out = 1'b1; c.pc_in = 1'b1; end
                        OP_IN:   begin c.inport_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
                        OP_OUT:  begin c.gra = 1'b1; c.r_out = 1'b1; c.outport_in = 1'b1; end
                        OP_MFHI: begin c.hi_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
                        OP_MFLO: begin c.lo_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
                        default: ;
                    endcase
                end
            end
            S_T4: begin
                if (is_alu(op)) begin
                    c.grc = 1'b1; c.r_out = 1'b1; c.z_in = 1'b1; c.alu_op = alu_sel(op);
                end else if (op == OP_BR) begin
                    c.pc_out = 1'b1; c.y_in = 1'b1;
                end else begin
                    c.c_out = 1'b1; c.z_in = 1'b1;
                end
            end
            S_T5: begin
                if (op == OP_BR) begin
                    c.c_out = 1'b1; c.z_in = 1'b1;
                end else if (is_mem(op)) begin
                    c.zlo_out = 1'b1; c.mar_in = 1'b1;
                end else begin
                    c.zlo_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1;
                end
            end
            S_T6: begin
                if (op == OP_BR) begin
                    c.zlo_out = 1'b1; c.pc_in_con = 1'b1;
                end else if (op == OP_ST) begin
                    c.gra = 1'b1; c.r_out = 1'b1; c.mdr_in = 1'b1;
                end else begin
                    c.read = 1'b1; c.mdr_in = 1'b1;
                end
            end
            S_T7: begin
                if (op == OP_ST) begin
                    c.write = 1'b1;
                end else begin
                    c.mdr_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1;
                end
            end
            default: ;
        endcase
        return c;
    endfunction

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        fin     = 1'b0;
        case (state_q)
            S_RESET: state_d = S_T0;
            S_T0:    state_d = S_T1;
            S_T1:    state_d = S_T2;
            S_T2: begin
                op_d = IR[31 -: OPW];
                if (op_d == OP_HALT)     state_d = S_HALT;
                else if (has_exec(op_d)) state_d = S_T3;
                else                     fin = 1'b1;
            end
            S_T3: begin
                if (is_short(op_q)) fin = 1'b1;
                else                state_d = S_T4;
            end
            S_T4: state_d = S_T5;
            S_T5: begin
                if (is_mem(op_q) || op_q == OP_BR) state_d = S_T6;
                else                               fin = 1'b1;
            end
            S_T6: begin
                if (is_mem(op_q)) state_d = S_T7;
                else              fin = 1'b1;
            end
            S_T7:   fin = 1'b1;
            S_HALT: state_d = S_HALT;
            default: state_d = S_RESET;
        endcase
        // Stop is honoured only where a new fetch would begin.
        if (fin) state_d = Stop ? S_HALT : S_T0;
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_RESET;
            op_q    <= '0;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            ctrl_q  <= decode(state_d, op_d);
        end
    end

    assign Run       = ctrl_q.run;
    assign PCout     = ctrl_q.pc_out;
    assign MDRout    = ctrl_q.mdr_out;
    assign ZLOout    = ctrl_q.zlo_out;
    assign ZHIout    = ctrl_q.zhi_out;
    assign HIout     = ctrl_q.hi_out;
    assign LOout     = ctrl_q.lo_out;
    assign INPORTout = ctrl_q.inport_out;
    assign Cout      = ctrl_q.c_out;
    // Branch T6 loads PC from CON as it stands during that step.
    assign PCin      = ctrl_q.pc_in | (ctrl_q.pc_in_con & CON);
    assign MARin     = ctrl_q.mar_in;
    assign MDRin     = ctrl_q.mdr_in;
    assign IRin      = ctrl_q.ir_in;
    assign Yin       = ctrl_q.y_in;
    assign Zin       = ctrl_q.z_in;
    assign HIin      = ctrl_q.hi_in;
    assign LOin      = ctrl_q.lo_in;
    assign OUTPORTin = ctrl_q.outport_in;
    assign CONin     = ctrl_q.con_in;
    assign Gra       = ctrl_q.gra;
    assign Grb       = ctrl_q.grb;
    assign Grc       = ctrl_q.grc;
    assign Rin       = ctrl_q.r_in;
    assign Rout      = ctrl_q.r_out;
    assign BAout     = ctrl_q.ba_out;
    assign Read      = ctrl_q.read;
    assign Write     = ctrl_q.write;
    assign IncPC     = ctrl_q.inc_pc;
    assign ALUop     = ctrl_q.alu_op;

endmodule

// File: tb/tb_mini_src_control_unit.sv
// Directed bench for mini_src_control_unit.
// Every output is packed into one word and compared per step against hand-built masks.
module tb_mini_src_control_unit;

    logic        Clock, Reset_n, CON, Stop;
    logic [31:0] IR;
    logic        Run, PCout, MDRout, ZLOout, ZHIout, HIout, LOout, INPORTout, Cout;
    logic        PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, OUTPORTin, CONin;
    logic        Gra, Grb, Grc, Rin, Rout, BAout, Read, Write, IncPC;
    logic [3:0]  ALUop;

    int n_tests = 0;
    int n_fail  = 0;

    mini_src_control_unit #(.OPW(5), .ALUW(4)) dut (
        .Clock(Clock), .Reset_n(Reset_n), .IR(IR), .CON(CON), .Stop(Stop),
        .Run(Run), .PCout(PCout), .MDRout(MDRout), .ZLOout(ZLOout), .ZHIout(ZHIout),
        .HIout(HIout), .LOout(LOout), .INPORTout(INPORTout), .Cout(Cout),
        .PCin(PCin), .MARin(MARin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Zin(Zin),
        .HIin(HIin), .LOin(LOin), .OUTPORTin(OUTPORTin), .CONin(CONin),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .Read(Read), .Write(Write), .IncPC(IncPC), .ALUop(ALUop)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    localparam logic [31:0] PCO  = 32'd1 << 0,  MDRO = 32'd1 << 1,  ZLO  = 32'd1 << 2;
    localparam logic [31:0] HIO  = 32'd1 << 4,  LOO  = 32'd1 << 5,  INPO = 32'd1 << 6;
    localparam logic [31:0] CO   = 32'd1 << 7,  PCI  = 32'd1 << 8,  MARI = 32'd1 << 9;
    localparam logic [31:0] MDRI = 32'd1 << 10, IRI  = 32'd1 << 11, YI   = 32'd1 << 12;
    localparam logic [31:0] ZI   = 32'd1 << 13, OUTI = 32'd1 << 16, CONI = 32'd1 << 17;
    localparam logic [31:0] GRA  = 32'd1 << 18, GRB  = 32'd1 << 19, GRC  = 32'd1 << 20;
    localparam logic [31:0] RIN  = 32'd1 << 21, ROUT = 32'd1 << 22, BAO  = 32'd1 << 23;
    localparam logic [31:0] RD   = 32'd1 << 24, WR   = 32'd1 << 25, INC  = 32'd1 << 26;
    localparam logic [31:0] RUN  = 32'd1 << 27;

    function automatic logic [31:0] ex(input logic [31:0] m, input int alu);
        return m | RUN | (32'(alu) << 28);
    endfunction

    logic [31:0] obs;
    assign obs = {ALUop, Run, IncPC, Write, Read, BAout, Rout, Rin, Grc, Grb, Gra,
                  CONin, OUTPORTin, LOin, HIin, Zin, Yin, IRin, MDRin, MARin, PCin,
                  Cout, INPORTout, LOout, HIout, ZHIout, ZLOout, MDRout, PCout};

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step(input string tag, input logic [31:0] exp);
        @(negedge Clock);
        check(tag, obs, exp);
    endtask

    task automatic fetch_rest(input string nm);
        step({nm, "_t1"}, ex(ZLO | PCI | RD | MDRI, 0));
        step({nm, "_t2"}, ex(MDRO | IRI, 0));
    endtask

    logic [31:0] t0e;

    initial begin
        t0e     = ex(PCO | MARI | INC | ZI, 0);
        Reset_n = 1'b0;
        IR      = 32'hC800_0000;
        CON     = 1'b0;
        Stop    = 1'b0;
        #1 check("reset_async", obs, 32'h0);
        step("reset_held", 32'h0);
        Reset_n = 1'b1;
        step("nop_t0", t0e);
        fetch_rest("nop");
        step("nop_back_t0", t0e);

        IR = 32'h1891_8000;
        fetch_rest("add");
        step("add_t3", ex(GRB | ROUT | YI, 0));
        step("add_t4", ex(GRC | ROUT | ZI, 0));
        step("add_t5", ex(ZLO | GRA | RIN, 0));
        step("add_t0", t0e);

        IR = 32'h2000_0000;
        fetch_rest("sub");
        step("sub_t3", ex(GRB | ROUT | YI, 0));
        step("sub_t4", ex(GRC | ROUT | ZI, 1));
        step("sub_t5", ex(ZLO | GRA | RIN, 0));
        step("sub_t0", t0e);

        IR = 32'h3000_0000;
        fetch_rest("or");
        step("or_t3", ex(GRB | ROUT | YI, 0));
        step("or_t4", ex(GRC | ROUT | ZI, 3));
        step("or_t5", ex(ZLO | GRA | RIN, 0));
        step("or_t0", t0e);

        for (int k = 1; k >= 0; k--) begin
            IR  = 32'h9000_0000;
            CON = k[0];
            fetch_rest("br");
            step("br_t3", ex(GRA | ROUT | CONI, 0));
            step("br_t4", ex(PCO | YI, 0));
            step("br_t5", ex(CO | ZI, 0));
            step(k[0] ? "br_t6_con1" : "br_t6_con0", ex(ZLO | (k[0] ? PCI : 32'h0), 0));
            step("br_t0", t0e);
        end

        IR = 32'h1000_0000;
        fetch_rest("st");
        step("st_t3", ex(GRB | BAO | YI, 0));
        step("st_t4", ex(CO | ZI, 0));
        step("st_t5", ex(ZLO | MARI, 0));
        step("st_t6", ex(GRA | ROUT | MDRI, 0));
        step("st_t7", ex(WR, 0));
        step("st_t0", t0e);

        IR = 32'h9800_0000;
        fetch_rest("jr");
        step("jr_t3", ex(GRA | ROUT | PCI, 0));
        step("jr_t0", t0e);

        IR = 32'hA800_0000;
        fetch_rest("in");
        step("in_t3", ex(INPO | GRA | RIN, 0));
        step("in_t0", t0e);

        IR = 32'hB000_0000;
        fetch_rest("out");
        step("out_t3", ex(GRA | ROUT | OUTI, 0));
        step("out_t0", t0e);

        IR = 32'hB800_0000;
        fetch_rest("mfhi");
        step("mfhi_t3", ex(HIO | GRA | RIN, 0));
        step("mfhi_t0", t0e);

        IR = 32'hC000_0000;
        fetch_rest("mflo");
        step("mflo_t3", ex(LOO | GRA | RIN, 0));
        step("mflo_t0", t0e);

        IR = 32'hF800_0000;
        fetch_rest("undef");
        step("undef_t0", t0e);

        IR = 32'h6000_0000;
        fetch_rest("addi");
        step("addi_t3", ex(GRB | ROUT | YI, 0));
        step("addi_t4", ex(CO | ZI, 0));
        Stop = 1'b1;
        step("addi_t5", ex(ZLO | GRA | RIN, 0));
        step("stop_halt", 32'h0);
        Stop = 1'b0;
        for (int k = 0; k < 3; k++) step("halt_hold", 32'h0);
        Reset_n = 1'b0;
        #1 check("halt_reset", obs, 32'h0);
        @(negedge Clock);
        Reset_n = 1'b1;
        IR = 32'h0000_0000;
        step("ld_t0", t0e);
        fetch_rest("ld");
        step("ld_t3", ex(GRB | BAO | YI, 0));
        step("ld_t4", ex(CO | ZI, 0));
        step("ld_t5", ex(ZLO | MARI, 0));
        step("ld_t6", ex(RD | MDRI, 0));
        #2 Reset_n = 1'b0;
        #1 check("ld_abort", obs, 32'h0);
        step("ld_abort_held", 32'h0);
        Reset_n = 1'b1;
        step("restart_t0", t0e);

        IR = 32'hD000_0000;
        fetch_rest("halt");
        step("halt_op", 32'h0);
        step("halt_op_hold", 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
